step_control_unit: RTL and testbench

Instruction sequencer that drives the four general-purpose registers R0–R3 and the other bus registers of the 8-bit stepped processor. It generates the set and enable strobes those registers consume. An internal stepper divides each instruction into six steps of two clock cycles each. The current instruction byte and ALU flags are decoded into one-hot register controls: enables are held for the whole step, and sets pulse in the step's second cycle. It sits directly upstream of the register bank, IAR, IR, MAR, TMP, ACC, RAM and flag register.

---
 rtl/step_control_if.sv | 41 ++++
 rtl/step_control_unit.sv | 216 +++++++++++++++++++++
 tb/tb_step_control_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_control_if.sv
// ============================================================================
// step_control_if : run/ir/flags inputs and register strobes of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface step_control_if;
   logic       run;
   logic [7:0] ir;
   logic [3:0] flags;
   logic [5:0] step;
   logic       phase;
   logic [3:0] reg_e;
   logic [3:0] reg_s;
   logic       iar_e;
   logic       iar_s;
   logic       acc_e;
   logic       acc_s;
   logic       ram_e;
   logic       ram_s;
   logic       mar_s;
   logic       ir_s;
   logic       tmp_s;
   logic       flags_s;
   logic       bus1;
   logic [2:0] alu_op;

   modport master (
      output run, ir, flags,
      input  step, phase, reg_e, reg_s, iar_e, iar_s, acc_e, acc_s,
             ram_e, ram_s, mar_s, ir_s, tmp_s, flags_s, bus1, alu_op
   );

   modport slave (
      input  run, ir, flags,
      output step, phase, reg_e, reg_s, iar_e, iar_s, acc_e, acc_s,
             ram_e, ram_s, mar_s, ir_s, tmp_s, flags_s, bus1, alu_op
   );
endinterface

`default_nettype wire

// File: rtl/step_control_unit.sv
// ============================================================================
// step_control_unit : six-step, two-phase instruction sequencer producing
//                     one-hot enable/set strobes for the 8-bit stepped CPU
// Rev 1.0
// ============================================================================
`default_nettype none

module step_control_unit (
   input  wire logic     clk,
   input  wire logic     reset,
   step_control_if.slave bus
);

   typedef enum logic [2:0] {
      ST_S1 = 3'd0,
      ST_S2 = 3'd1,
      ST_S3 = 3'd2,
      ST_S4 = 3'd3,
      ST_S5 = 3'd4,
      ST_S6 = 3'd5
   } step_t;

   step_t step_q, step_d;
   logic  phase_q, phase_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q  <= ST_S1;
         phase_q <= 1'b0;
      end else begin
         step_q  <= step_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      step_d  = step_q;
      phase_d = phase_q;
      if (bus.run) begin
         if (!phase_q) begin
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            case (step_q)
               ST_S1:   step_d = ST_S2;
               ST_S2:   step_d = ST_S3;
               ST_S3:   step_d = ST_S4;
               ST_S4:   step_d = ST_S5;
               ST_S5:   step_d = ST_S6;
               default: step_d = ST_S1;
            endcase
         end
      end
   end

   logic       w_is_alu;
   logic [3:0] w_cls;
   logic [2:0] w_op;
   logic [3:0] w_ra_oh;
   logic [3:0] w_rb_oh;
   logic       w_cond;

   assign w_is_alu = bus.ir[7];
   assign w_cls    = bus.ir[7:4];
   assign w_op     = bus.ir[6:4];
   assign w_ra_oh  = 4'b0001 << bus.ir[3:2];
   assign w_rb_oh  = 4'b0001 << bus.ir[1:0];
   assign w_cond   = |(bus.ir[3:0] & bus.flags);

   // Raw per-step decode; reset/phase/run gating is applied afterwards.
   logic [3:0] w_reg_e, w_reg_s;
   logic       w_iar_e, w_acc_e, w_ram_e, w_bus1;
   logic       w_iar_s, w_acc_s, w_ram_s, w_mar_s, w_ir_s, w_tmp_s, w_flags_s;
   logic [2:0] w_alu_op;

   always_comb begin
      w_reg_e   = 4'b0000;
      w_reg_s   = 4'b0000;
      w_iar_e   = 1'b0;
      w_acc_e   = 1'b0;
      w_ram_e   = 1'b0;
      w_bus1    = 1'b0;
      w_iar_s   = 1'b0;
      w_acc_s   = 1'b0;
      w_ram_s   = 1'b0;
      w_mar_s   = 1'b0;
      w_ir_s    = 1'b0;
      w_tmp_s   = 1'b0;
      w_flags_s = 1'b0;
      w_alu_op  = 3'b000;
      case (step_q)
         ST_S1: begin
            w_bus1  = 1'b1;
            w_iar_e = 1'b1;
            w_mar_s = 1'b1;
            w_acc_s = 1'b1;
         end
         ST_S2: begin
            w_ram_e = 1'b1;
            w_ir_s  = 1'b1;
         end
         ST_S3: begin
            w_acc_e = 1'b1;
            w_iar_s = 1'b1;
         end
         ST_S4: begin
            if (w_is_alu) begin
               w_reg_e = w_rb_oh;
               w_tmp_s = 1'b1;
            end else begin
               case (w_cls)
                  4'h0, 4'h1: begin
                     w_reg_e = w_ra_oh;
                     w_mar_s = 1'b1;
                  end
                  4'h2, 4'h5: begin
                     w_bus1  = 1'b1;
                     w_iar_e = 1'b1;
                     w_mar_s = 1'b1;
                     w_acc_s = 1'b1;
                  end
                  4'h3: begin
                     w_reg_e = w_rb_oh;
                     w_iar_s = 1'b1;
                  end
                  4'h4: begin
                     w_iar_e = 1'b1;
                     w_mar_s = 1'b1;
                  end
                  4'h6: begin
                     w_bus1    = 1'b1;
                     w_flags_s = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_S5: begin
            if (w_is_alu) begin
               w_reg_e   = w_ra_oh;
               w_alu_op  = w_op;
               w_acc_s   = 1'b1;
               w_flags_s = 1'b1;
            end else begin
               case (w_cls)
                  4'h0, 4'h2: begin
                     w_ram_e = 1'b1;
                     w_reg_s = w_rb_oh;
                  end
                  4'h1: begin
                     w_reg_e = w_rb_oh;
                     w_ram_s = 1'b1;
                  end
                  4'h4: begin
                     w_ram_e = 1'b1;
                     w_iar_s = 1'b1;
                  end
                  4'h5: begin
                     w_acc_e = 1'b1;
                     w_iar_s = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_S6: begin
            if (w_is_alu) begin
               w_acc_e = 1'b1;
               // CMP only updates flags; the result is discarded.
               if (w_op != 3'b111) w_reg_s = w_rb_oh;
            end else begin
               case (w_cls)
                  4'h2: begin
                     w_acc_e = 1'b1;
                     w_iar_s = 1'b1;
                  end
                  4'h5: begin
                     if (w_cond) begin
                        w_ram_e = 1'b1;
                        w_iar_s = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   logic w_en_ok;
   logic w_set_ok;

   assign w_en_ok  = ~reset;
   assign w_set_ok = phase_q & bus.run & ~reset;

   assign bus.step    = 6'b000001 << step_q;
   assign bus.phase   = phase_q;
   assign bus.reg_e   = w_en_ok ? w_reg_e : 4'b0000;
   assign bus.iar_e   = w_en_ok & w_iar_e;
   assign bus.acc_e   = w_en_ok & w_acc_e;
   assign bus.ram_e   = w_en_ok & w_ram_e;
   assign bus.bus1    = w_en_ok & w_bus1;
   assign bus.alu_op  = w_en_ok ? w_alu_op : 3'b000;
   assign bus.reg_s   = w_set_ok ? w_reg_s : 4'b0000;
   assign bus.iar_s   = w_set_ok & w_iar_s;
   assign bus.acc_s   = w_set_ok & w_acc_s;
   assign bus.ram_s   = w_set_ok & w_ram_s;
   assign bus.mar_s   = w_set_ok & w_mar_s;
   assign bus.ir_s    = w_set_ok & w_ir_s;
   assign bus.tmp_s   = w_set_ok & w_tmp_s;
   assign bus.flags_s = w_set_ok & w_flags_s;

endmodule

`default_nettype wire

// File: tb/tb_step_control_unit.sv
// Bench for step_control_unit: instruction-level model compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
`default_nettype none

module tb_step_control_unit;

   typedef struct packed {
      logic [5:0] step;
      logic       phase;
      logic [3:0] reg_e;
      logic [3:0] reg_s;
      logic       iar_e, iar_s, acc_e, acc_s, ram_e, ram_s;
      logic       mar_s, ir_s, tmp_s, flags_s, bus1;
      logic [2:0] alu_op;
   } obs_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   pos_m;
   logic model_valid;
   obs_t cap [12];

   step_control_if sci ();

   step_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sci)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.step = sci.step;   o.phase = sci.phase;
      o.reg_e = sci.reg_e; o.reg_s = sci.reg_s;
      o.iar_e = sci.iar_e; o.iar_s = sci.iar_s;
      o.acc_e = sci.acc_e; o.acc_s = sci.acc_s;
      o.ram_e = sci.ram_e; o.ram_s = sci.ram_s;
      o.mar_s = sci.mar_s; o.ir_s = sci.ir_s;
      o.tmp_s = sci.tmp_s; o.flags_s = sci.flags_s;
      o.bus1 = sci.bus1;   o.alu_op = sci.alu_op;
      return o;
   endfunction

   // Instruction-table model: position 0..11 within the instruction.
   function automatic obs_t model(int pos, logic rst, logic rn,
                                  logic [7:0] iv, logic [3:0] fl);
      obs_t e;
      int s;
      logic ph;
      logic [3:0] a_oh, b_oh, rs;
      logic ias, acs, ras, mas, irs, tms, fls;
      e  = '0;
      s  = pos / 2 + 1;
      ph = (pos % 2) == 1;
      e.step  = 6'(1 << (s - 1));
      e.phase = ph;
      if (rst) return e;
      a_oh = 4'(1 << iv[3:2]);
      b_oh = 4'(1 << iv[1:0]);
      rs = 4'b0; ias = 0; acs = 0; ras = 0; mas = 0; irs = 0; tms = 0; fls = 0;
      if (s == 1) begin e.bus1 = 1; e.iar_e = 1; mas = 1; acs = 1; end
      else if (s == 2) begin e.ram_e = 1; irs = 1; end
      else if (s == 3) begin e.acc_e = 1; ias = 1; end
      else if (iv[7]) begin
         if (s == 4) begin e.reg_e = b_oh; tms = 1; end
         if (s == 5) begin e.reg_e = a_oh; e.alu_op = iv[6:4]; acs = 1; fls = 1; end
         if (s == 6) begin e.acc_e = 1; rs = (iv[6:4] == 3'd7) ? 4'b0 : b_oh; end
      end else begin
         case (iv[7:4])
            4'h0: begin
               if (s == 4) begin e.reg_e = a_oh; mas = 1; end
               if (s == 5) begin e.ram_e = 1; rs = b_oh; end
            end
            4'h1: begin
               if (s == 4) begin e.reg_e = a_oh; mas = 1; end
               if (s == 5) begin e.reg_e = b_oh; ras = 1; end
            end
            4'h2: begin
               if (s == 4) begin e.bus1 = 1; e.iar_e = 1; mas = 1; acs = 1; end
               if (s == 5) begin e.ram_e = 1; rs = b_oh; end
               if (s == 6) begin e.acc_e = 1; ias = 1; end
            end
            4'h3: if (s == 4) begin e.reg_e = b_oh; ias = 1; end
            4'h4: begin
               if (s == 4) begin e.iar_e = 1; mas = 1; end
               if (s == 5) begin e.ram_e = 1; ias = 1; end
            end
            4'h5: begin
               if (s == 4) begin e.bus1 = 1; e.iar_e = 1; mas = 1; acs = 1; end
               if (s == 5) begin e.acc_e = 1; ias = 1; end
               if (s == 6 && (iv[3:0] & fl) != 4'b0) begin e.ram_e = 1; ias = 1; end
            end
            4'h6: if (s == 4) begin e.bus1 = 1; fls = 1; end
            default: ;
         endcase
      end
      if (ph && rn) begin
         e.reg_s = rs; e.iar_s = ias; e.acc_s = acs; e.ram_s = ras;
         e.mar_s = mas; e.ir_s = irs; e.tmp_s = tms; e.flags_s = fls;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         pos_m       <= 0;
         model_valid <= 1'b1;
      end else if (model_valid && sci.run) begin
         pos_m <= (pos_m + 1) % 12;
      end
   end

   always @(negedge clk) begin
      obs_t got, exp_o;
      if (model_valid === 1'b1) begin
         got   = sample();
         exp_o = model(pos_m, reset, sci.run, sci.ir, sci.flags);
         n_checks++;
         if (got !== exp_o) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t pos=%0d got=%h exp=%h", $time, pos_m, got, exp_o);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [7:0] iv, input logic [3:0] fl);
      for (int p = 0; p < 12; p++) begin
         sci.ir    = iv;
         sci.flags = fl;
         @(negedge clk);
         cap[p] = sample();
         adv();
      end
   endtask

   task automatic run_cycles(input int n);
      for (int p = 0; p < n; p++) begin
         @(negedge clk);
         adv();
      end
   endtask

   initial begin
      obs_t idle;
      n_checks    = 0;
      n_fail      = 0;
      model_valid = 1'b0;
      pos_m       = 0;
      reset       = 1'b1;
      sci.run     = 1'b1;
      sci.ir      = 8'h00;
      sci.flags   = 4'h0;

      adv();
      @(negedge clk);
      chk("reset_bus1", 32'(sci.bus1), 32'd0);
      chk("reset_iar_e", 32'(sci.iar_e), 32'd0);
      chk("reset_step", 32'(sci.step), 32'h01);
      adv();
      reset = 1'b0;

      // LD with ir=0x00 for two instructions
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("c1_step", 32'(sci.step), 32'h01);
            chk("c1_phase", 32'(sci.phase), 32'd0);
         end
         if (c == 2 || c == 8 || c == 14) chk("mar_s_pulse", 32'(sci.mar_s), 32'd1);
         if (c == 3) chk("mar_s_low", 32'(sci.mar_s), 32'd0);
         if (c == 4 || c == 16) chk("ir_s_pulse", 32'(sci.ir_s), 32'd1);
         if (c == 12) chk("c12_step", 32'({sci.step, sci.phase}), 32'({6'b100000, 1'b1}));
         adv();
      end

      // ADD R1,R2
      run_instr(8'h86, 4'h0);
      chk("add_s4_reg_e", 32'(cap[6].reg_e), 32'h4);
      chk("add_s4_tmp_s_p0", 32'(cap[6].tmp_s), 32'd0);
      chk("add_s4_tmp_s_p1", 32'(cap[7].tmp_s), 32'd1);
      chk("add_s5_reg_e", 32'(cap[9].reg_e), 32'h2);
      chk("add_s5_alu_op", 32'(cap[9].alu_op), 32'd0);
      chk("add_s5_acc_flags", 32'({cap[9].acc_s, cap[9].flags_s}), 32'h3);
      chk("add_s6_acc_e", 32'(cap[11].acc_e), 32'd1);
      chk("add_s6_reg_s", 32'(cap[11].reg_s), 32'h4);
      chk("add_s6_reg_s_p0", 32'(cap[10].reg_s), 32'h0);

      // CMP R0,R1
      run_instr(8'hF1, 4'h0);
      chk("cmp_alu_op", 32'(cap[9].alu_op), 32'd7);
      chk("cmp_flags_s", 32'(cap[9].flags_s), 32'd1);
      chk("cmp_reg_s", 32'(cap[11].reg_s), 32'h0);

      // JCOND taken / not taken
      run_instr(8'h52, 4'b0010);
      chk("jc_taken_ram_e", 32'(cap[10].ram_e), 32'd1);
      chk("jc_taken_iar_s", 32'(cap[11].iar_s), 32'd1);
      run_instr(8'h52, 4'b0101);
      idle = '0;
      idle.step = 6'b100000;
      chk("jc_not_taken_p0", 32'(cap[10]), 32'(idle));
      idle.phase = 1'b1;
      chk("jc_not_taken_p1", 32'(cap[11]), 32'(idle));

      // Remaining classes, checked by the model
      run_instr(8'h1B, 4'h0);
      run_instr(8'h27, 4'h0);
      run_instr(8'h39, 4'h0);
      run_instr(8'h40, 4'h0);
      run_instr(8'h60, 4'hF);
      run_instr(8'h7F, 4'hF);
      run_instr(8'hC5, 4'h0);
      run_instr(8'h5F, 4'b1000);

      // run dropped at (S3,1)
      sci.ir = 8'h00;
      sci.flags = 4'h0;
      run_cycles(5);
      sci.run = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_step", 32'({sci.step, sci.phase}), 32'({6'b000100, 1'b1}));
         chk("hold_iar_s", 32'(sci.iar_s), 32'd0);
         chk("hold_acc_e", 32'(sci.acc_e), 32'd1);
         adv();
      end
      sci.run = 1'b1;
      @(negedge clk);
      chk("resume_iar_s", 32'(sci.iar_s), 32'd1);
      adv();
      @(negedge clk);
      chk("resume_step", 32'({sci.step, sci.phase}), 32'({6'b001000, 1'b0}));
      adv();
      run_cycles(5);

      // reset at (S5,1) during LD
      run_cycles(9);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_reg_s", 32'(sci.reg_s), 32'h0);
      chk("rst_mid_ram_e", 32'(sci.ram_e), 32'd0);
      adv();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_next", 32'({sci.step, sci.phase}), 32'({6'b000001, 1'b0}));
      adv();
      run_cycles(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
